prog_ram_loader: RTL

- Parametrised program-memory block for the 8-bit CPU.
- Owns the RAM array and arbitrates between two ports:
  - an asynchronous, pin-driven programming port: prog mode, strobe, address, data, with readback on the bidirectional bus;
  - the CPU's synchronous read/write port.
- Adds synchronisers, strobe edge detection, an auto-increment load pointer and readback with output enable.
- Sits between the top-level pin wrapper and the CPU core.

---
 rtl/eater_pkg.sv | 12 +
 rtl/pin_sync.sv | 32 +++
 rtl/prog_ram_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/eater_pkg.sv
// Shared constants and types for the 8-bit CPU program memory.
// Default widths, synchroniser depth and word/address typedefs.
package eater_pkg;

   localparam int DATA_W_DEF      = 8;
   localparam int ADDR_W_DEF      = 4;
   localparam int SYNC_STAGES_DEF = 2;

   typedef logic [DATA_W_DEF-1:0] data_t;
   typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop pin synchroniser with one extra flop for edge detection.
// level is the synchronised pin, rise pulses for one cycle on a 0->1.
module pin_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] pin,
   output logic [W-1:0] level,
   output logic [W-1:0] rise
);

   logic [W-1:0] chain [STAGES];
   logic [W-1:0] level_d;

   // shift the pin through the synchroniser chain plus the edge flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
         level_d <= '0;
      end else begin
         chain[0] <= pin;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
         level_d <= chain[STAGES-1];
      end
   end

   assign level = chain[STAGES-1];
   assign rise  = chain[STAGES-1] & ~level_d;

endmodule

// File: rtl/prog_ram_loader.sv
// Program RAM with a pin-driven programming port and a CPU port.
// The programming port always wins; CPU writes in prog mode are dropped.
module prog_ram_loader
   import eater_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prog_mode_pin,
   input  logic              auto_inc_pin,
   input  logic              wr_strobe_pin,
   input  logic [ADDR_W-1:0] prog_addr_pin,
   input  logic [DATA_W-1:0] prog_data_in,
   output logic [DATA_W-1:0] prog_data_out,
   output logic              prog_oe,
   output logic [ADDR_W-1:0] load_ptr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              wr_drop
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic pm_s, pm_rise;
   logic ai_s, unused_ai_rise;
   logic st_s, st_rise;

   logic              wp;
   logic              cpu_commit;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] prog_sel;
   logic [DATA_W-1:0] rb_next;
   logic [DATA_W-1:0] cpu_next;

   pin_sync #(.W(1), .STAGES(SYNC_STAGES)) u_pm_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (prog_mode_pin),
      .level (pm_s),
      .rise  (pm_rise)
   );

   pin_sync #(.W(1), .STAGES(SYNC_STAGES)) u_ai_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (auto_inc_pin),
      .level (ai_s),
      .rise  (unused_ai_rise)
   );

   pin_sync #(.W(1), .STAGES(SYNC_STAGES)) u_st_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (wr_strobe_pin),
      .level (st_s),
      .rise  (st_rise)
   );

   // arbitrate the single write port and form write-first read data
   always_comb begin
      wp         = st_rise & pm_s;
      cpu_commit = cpu_we & ~pm_s;
      prog_sel   = ai_s ? load_ptr : prog_addr_pin;
      wr_en      = 1'b0;
      wr_addr    = cpu_addr;
      wr_data    = cpu_wdata;
      if (wp) begin
         wr_en   = 1'b1;
         wr_addr = prog_sel;
         wr_data = prog_data_in;
      end else if (cpu_commit) begin
         wr_en = 1'b1;
      end
      rb_next  = mem[prog_sel];
      cpu_next = mem[cpu_addr];
      if (wr_en && wr_addr == prog_sel) rb_next = wr_data;
      if (wr_en && wr_addr == cpu_addr) cpu_next = wr_data;
   end

   generate
      if (CLEAR_ON_RESET) begin : g_mem_clr
         // RAM array, zeroed by reset
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (wr_en) begin
               mem[wr_addr] <= wr_data;
            end
         end
      end else begin : g_mem_keep
         // RAM array, contents survive reset; no write while in reset
         always_ff @(posedge clk) begin
            if (rst_n && wr_en) mem[wr_addr] <= wr_data;
         end
      end
   endgenerate

   // load pointer: preload on mode entry, bump on auto-inc writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_ptr <= '0;
      end else if (wp && ai_s) begin
         load_ptr <= load_ptr + 1'b1;
      end else if (pm_rise) begin
         load_ptr <= prog_addr_pin;
      end
   end

   // registered read data for both ports and the drop pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prog_data_out <= '0;
         cpu_rdata     <= '0;
         wr_drop       <= 1'b0;
      end else begin
         prog_data_out <= rb_next;
         cpu_rdata     <= cpu_next;
         wr_drop       <= cpu_we & pm_s;
      end
   end

   assign prog_oe   = pm_s & ~st_s;
   assign cpu_stall = pm_s;

endmodule
